// File: rtl/xm_mem_pkg.sv
// Shared types and constants for the memory address sequencer.
// Mode codes outside the named set decode as DIRECT.
package xm_mem_pkg;

    typedef enum logic [2:0] {
        PRE_INC  = 3'd0,
        POST_INC = 3'd1,
        PRE_DEC  = 3'd2,
        POST_DEC = 3'd3,
        INDEXED  = 3'd4,
        DIRECT   = 3'd5
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int STEP_WORD = 2;
    localparam int STEP_BYTE = 1;

    function automatic addr_mode_t decode_mode(input logic [2:0] code);
        if (code > 3'd5) begin
            return DIRECT;
        end
        return addr_mode_t'(code);
    endfunction

    function automatic logic is_inc_dec(input addr_mode_t mode);
        return (mode == PRE_INC) || (mode == POST_INC) ||
               (mode == PRE_DEC) || (mode == POST_DEC);
    endfunction

endpackage

// File: rtl/addr_offset_mux.sv
// Selects the signed delta added to the base register, both for the effective
// address and for the write-back value, from addressing mode and access size.
module addr_offset_mux
    import xm_mem_pkg::*;
#(
    parameter int WORD = 16
) (
    input  logic [2:0]      mode,
    input  logic            byte_sel,
    input  logic [WORD-1:0] offset,
    output logic [WORD-1:0] ea_delta,
    output logic [WORD-1:0] upd_delta
);

    logic [WORD-1:0] step;
    logic [WORD-1:0] neg_step;

    // Negative step is the two's complement so a plain add wraps modulo 2^WORD.
    assign step     = byte_sel ? WORD'(STEP_BYTE) : WORD'(STEP_WORD);
    assign neg_step = '0 - step;

    always_comb begin
        ea_delta  = '0;
        upd_delta = '0;
        case (decode_mode(mode))
            PRE_INC: begin
                ea_delta  = step;
                upd_delta = step;
            end
            POST_INC: begin
                upd_delta = step;
            end
            PRE_DEC: begin
                ea_delta  = neg_step;
                upd_delta = neg_step;
            end
            POST_DEC: begin
                upd_delta = neg_step;
            end
            INDEXED: begin
                ea_delta = offset;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Address-generation sequencer: latches an addressing request, computes the
// effective address, issues a memory request and reports base write-back.
module mem_addr_sequencer
    import xm_mem_pkg::*;
#(
    parameter int WORD      = 16,
    parameter int ALIGN_CHK = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      mode_i,
    input  logic            byte_i,
    input  logic [WORD-1:0] base_i,
    input  logic [WORD-1:0] offset_i,
    input  logic            mem_ack_i,
    output logic            mem_req_o,
    output logic [WORD-1:0] addr_o,
    output logic            wb_en_o,
    output logic [WORD-1:0] wb_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    seq_state_t      state;
    seq_state_t      next_state;
    addr_mode_t      mode_q;
    logic            byte_q;
    logic [WORD-1:0] base_q;
    logic [WORD-1:0] offset_q;
    logic [WORD-1:0] ea_q;
    logic [WORD-1:0] upd_q;
    logic            err_q;

    logic [WORD-1:0] ea_delta;
    logic [WORD-1:0] upd_delta;
    logic [WORD-1:0] ea_calc;
    logic            align_err;

    addr_offset_mux #(.WORD(WORD)) u_offset_mux (
        .mode      (mode_q),
        .byte_sel  (byte_q),
        .offset    (offset_q),
        .ea_delta  (ea_delta),
        .upd_delta (upd_delta)
    );

    // Byte accesses never fault; word accesses must land on an even address.
    assign ea_calc   = base_q + ea_delta;
    assign align_err = (ALIGN_CHK != 0) && !byte_q && ea_calc[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= PRE_INC;
            byte_q   <= 1'b0;
            base_q   <= '0;
            offset_q <= '0;
            ea_q     <= '0;
            upd_q    <= '0;
            err_q    <= 1'b0;
        end else if (state == IDLE && start_i) begin
            mode_q   <= decode_mode(mode_i);
            byte_q   <= byte_i;
            base_q   <= base_i;
            offset_q <= offset_i;
        end else if (state == CALC) begin
            ea_q  <= ea_calc;
            upd_q <= base_q + upd_delta;
            err_q <= align_err;
        end
    end

    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        mem_req_o  = 1'b0;
        addr_o     = '0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        wb_en_o    = 1'b0;
        wb_data_o  = '0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                busy_o     = 1'b1;
                next_state = align_err ? DONE : REQ;
            end
            REQ: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                addr_o    = ea_q;
                if (mem_ack_i) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                err_o      = err_q;
                wb_en_o    = !err_q && is_inc_dec(mode_q);
                wb_data_o  = upd_q;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Self-checking bench for mem_addr_sequencer: directed vector table, corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_mem_addr_sequencer;

    localparam int WORD = 16;

    logic            clk_i;
    logic            rst_i;
    logic            start_i;
    logic [2:0]      mode_i;
    logic            byte_i;
    logic [WORD-1:0] base_i;
    logic [WORD-1:0] offset_i;
    logic            mem_ack_i;
    logic            mem_req_o;
    logic [WORD-1:0] addr_o;
    logic            wb_en_o;
    logic [WORD-1:0] wb_data_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic [2:0]  mode;
        logic        byt;
        logic [15:0] base;
        logic [15:0] off;
        int          delay;
        logic [15:0] exp_addr;
        logic        exp_err;
        logic        exp_wb_en;
        logic [15:0] exp_wb_data;
    } vec_t;

    vec_t vecs[9];

    mem_addr_sequencer #(.WORD(WORD), .ALIGN_CHK(1)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .byte_i    (byte_i),
        .base_i    (base_i),
        .offset_i  (offset_i),
        .mem_ack_i (mem_ack_i),
        .mem_req_o (mem_req_o),
        .addr_o    (addr_o),
        .wb_en_o   (wb_en_o),
        .wb_data_o (wb_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: effective address and write-back from the addressing rules.
    function automatic void model_op(input logic [2:0] mode, input logic byt,
                                     input logic [15:0] base, input logic [15:0] off,
                                     output logic [15:0] ea, output logic err,
                                     output logic wb_en, output logic [15:0] wb_data);
        logic [15:0] step;
        step = byt ? 16'd1 : 16'd2;
        case (mode)
            3'd0: begin ea = base + step; wb_data = base + step; end
            3'd1: begin ea = base;        wb_data = base + step; end
            3'd2: begin ea = base - step; wb_data = base - step; end
            3'd3: begin ea = base;        wb_data = base - step; end
            3'd4: begin ea = base + off;  wb_data = base;        end
            default: begin ea = base;     wb_data = base;        end
        endcase
        err   = !byt && ea[0];
        wb_en = (mode <= 3'd3) && !err;
    endfunction

    task automatic apply_stimulus(input string tag, input logic [2:0] mode, input logic byt,
                                  input logic [15:0] base, input logic [15:0] off,
                                  input int delay, input logic [15:0] exp_addr,
                                  input logic exp_err, input logic exp_wb_en,
                                  input logic [15:0] exp_wb_data);
        @(negedge clk_i);
        start_i   = 1'b1;
        mode_i    = mode;
        byte_i    = byt;
        base_i    = base;
        offset_i  = off;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        start_i   = 1'b0;
        mem_ack_i = 1'($urandom_range(0, 1));
        mode_i    = 3'($urandom);
        base_i    = 16'($urandom);
        check_output({tag, ".calc_busy"}, 32'(busy_o), 32'd1);
        check_output({tag, ".calc_req"}, 32'(mem_req_o), 32'd0);
        if (exp_err) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            check_output({tag, ".err_done"}, 32'(done_o), 32'd1);
            check_output({tag, ".err_flag"}, 32'(err_o), 32'd1);
            check_output({tag, ".err_req"}, 32'(mem_req_o), 32'd0);
            check_output({tag, ".err_wb_en"}, 32'(wb_en_o), 32'd0);
        end else begin
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk_i);
                check_output({tag, ".req"}, 32'(mem_req_o), 32'd1);
                check_output({tag, ".addr"}, 32'(addr_o), 32'(exp_addr));
                check_output({tag, ".req_done"}, 32'(done_o), 32'd0);
                mem_ack_i = (k == delay);
                start_i   = 1'($urandom_range(0, 1));
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            start_i   = 1'b0;
            check_output({tag, ".done"}, 32'(done_o), 32'd1);
            check_output({tag, ".err"}, 32'(err_o), 32'd0);
            check_output({tag, ".wb_en"}, 32'(wb_en_o), 32'(exp_wb_en));
            if (exp_wb_en) begin
                check_output({tag, ".wb_data"}, 32'(wb_data_o), 32'(exp_wb_data));
            end
            check_output({tag, ".done_req"}, 32'(mem_req_o), 32'd0);
            check_output({tag, ".done_addr"}, 32'(addr_o), 32'd0);
        end
        @(negedge clk_i);
        check_output({tag, ".idle_busy"}, 32'(busy_o), 32'd0);
        check_output({tag, ".idle_done"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  r_mode;
        logic        r_byt;
        logic [15:0] r_base;
        logic [15:0] r_off;
        logic [15:0] m_ea;
        logic [15:0] m_wb;
        logic        m_err;
        logic        m_wb_en;
        int          done_count;

        checks_total  = 0;
        checks_passed = 0;

        vecs[0] = '{3'd1, 1'b0, 16'h1000, 16'h0000, 0, 16'h1000, 1'b0, 1'b1, 16'h1002};
        vecs[1] = '{3'd2, 1'b1, 16'h0000, 16'h0000, 0, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF};
        vecs[2] = '{3'd4, 1'b0, 16'h2000, 16'hFFFD, 0, 16'h1FFD, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{3'd5, 1'b0, 16'h3456, 16'h0000, 5, 16'h3456, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{3'd0, 1'b0, 16'hFFFE, 16'h0000, 1, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[5] = '{3'd3, 1'b1, 16'h0001, 16'h0000, 2, 16'h0001, 1'b0, 1'b1, 16'h0000};
        vecs[6] = '{3'd7, 1'b0, 16'h1235, 16'h0000, 0, 16'h1235, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{3'd4, 1'b1, 16'h1000, 16'h0003, 0, 16'h1003, 1'b0, 1'b0, 16'h0000};
        vecs[8] = '{3'd0, 1'b0, 16'h0001, 16'h0000, 0, 16'h0003, 1'b1, 1'b0, 16'h0000};

        rst_i     = 1'b1;
        start_i   = 1'b1;
        mode_i    = 3'd0;
        byte_i    = 1'b0;
        base_i    = '0;
        offset_i  = '0;
        mem_ack_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_output("reset.busy", 32'(busy_o), 32'd0);
        check_output("reset.req", 32'(mem_req_o), 32'd0);
        check_output("reset.addr", 32'(addr_o), 32'd0);
        check_output("reset.done", 32'(done_o), 32'd0);
        check_output("reset.err", 32'(err_o), 32'd0);
        check_output("reset.wb_en", 32'(wb_en_o), 32'd0);
        check_output("reset.wb_data", 32'(wb_data_o), 32'd0);
        rst_i     = 1'b0;
        start_i   = 1'b0;
        mem_ack_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].byt, vecs[i].base,
                           vecs[i].off, vecs[i].delay, vecs[i].exp_addr, vecs[i].exp_err,
                           vecs[i].exp_wb_en, vecs[i].exp_wb_data);
        end

        // Reset asserted while a request is outstanding must abort cleanly.
        @(negedge clk_i);
        start_i = 1'b1;
        mode_i  = 3'd5;
        byte_i  = 1'b0;
        base_i  = 16'h7770;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check_output("rst_mid.req_before", 32'(mem_req_o), 32'd1);
        rst_i     = 1'b1;
        mem_ack_i = 1'b1;
        start_i   = 1'b1;
        @(negedge clk_i);
        rst_i     = 1'b0;
        mem_ack_i = 1'b0;
        start_i   = 1'b0;
        check_output("rst_mid.busy", 32'(busy_o), 32'd0);
        check_output("rst_mid.req", 32'(mem_req_o), 32'd0);
        check_output("rst_mid.addr", 32'(addr_o), 32'd0);
        check_output("rst_mid.done", 32'(done_o), 32'd0);
        apply_stimulus("after_rst", 3'd1, 1'b1, 16'h00FF, 16'h0000, 0,
                       16'h00FF, 1'b0, 1'b1, 16'h0100);

        // Back-to-back: start and ack held high, one done pulse every four cycles.
        @(negedge clk_i);
        start_i    = 1'b1;
        mode_i     = 3'd1;
        byte_i     = 1'b0;
        base_i     = 16'h4000;
        offset_i   = '0;
        mem_ack_i  = 1'b1;
        done_count = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            check_output($sformatf("b2b.done_c%0d", c), 32'(done_o), 32'((c % 4) == 3));
            if (done_o) begin
                done_count++;
                check_output($sformatf("b2b.wb_data_c%0d", c), 32'(wb_data_o), 32'h4002);
            end
        end
        start_i   = 1'b0;
        mem_ack_i = 1'b0;
        check_output("b2b.done_count", 32'(done_count), 32'd3);
        @(negedge clk_i);
        check_output("b2b.idle", 32'(busy_o), 32'd0);

        for (int n = 0; n < 40; n++) begin
            r_mode = 3'($urandom_range(0, 7));
            r_byt  = 1'($urandom_range(0, 1));
            r_base = 16'($urandom);
            r_off  = 16'($urandom);
            model_op(r_mode, r_byt, r_base, r_off, m_ea, m_err, m_wb_en, m_wb);
            apply_stimulus($sformatf("rand%0d", n), r_mode, r_byt, r_base, r_off,
                           $urandom_range(0, 3), m_ea, m_err, m_wb_en, m_wb);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
